pll_rst_seq: RTL and testbench

//  Reset/lock sequencer wrapped around the system PLL, which takes the 24 MHz refclk and produces clk0 at 20 MHz and clk1 at 10 MHz.
//  - Runs on the free-running 24 MHz refclk.
//  - Drives the PLL reset input and consumes the PLL extlock output.
//  - Issues a lock-qualified system reset that downstream clk0/clk1 domains resynchronise.
//  - Re-resets the PLL on lock timeout or sustained lock loss.

---
 rtl/pll_rst_seq_pkg.sv | 27 ++
 rtl/pll_rst_seq_sync_2ff.sv | 36 +++
 rtl/pll_rst_seq.sv | 176 +++++++++++++++++
 tb/tb_pll_rst_seq.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pll_rst_seq_pkg.sv
// ----------------------------------------------------------------------------
// pll_rst_seq_pkg
// Shared definitions for the PLL reset/lock sequencer:
//   - state_t : sequencer state encoding (2 bits)
//               PLL_RST=0, WAIT_LOCK=1, STABLE=2, RUN=3
//   - SAT_W   : width of the saturating event counters (retry_cnt, loss_cnt)
//   - sat_inc : saturating increment helper for those counters
// No ports (package).
// ----------------------------------------------------------------------------
package pll_rst_seq_pkg;

    typedef enum logic [1:0] {
        ST_PLL_RST   = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_STABLE    = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    localparam int SAT_W = 8;

    // Counters stick at all-ones rather than wrapping, so a large value
    // always means "at least this many" events.
    function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v);
        return (v == {SAT_W{1'b1}}) ? v : v + SAT_W'(1);
    endfunction

endpackage

// File: rtl/pll_rst_seq_sync_2ff.sv
// ----------------------------------------------------------------------------
// sync_2ff
// Generic two-flop synchroniser for a single-bit level crossing into clk_i.
// Both flops clear on the asynchronous active-high reset. Also used by the
// downstream clk0/clk1 reset bridges.
// Ports:
//   clk_i : destination clock
//   rst_i : asynchronous reset, active-high
//   d_i   : asynchronous input level
//   q_o   : synchronised level, two clk_i cycles of latency
// ----------------------------------------------------------------------------
module sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // First flop may go metastable; the second gives it a full cycle to
    // settle before anything downstream looks at the value.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_rst_seq.sv
// ----------------------------------------------------------------------------
// pll_rst_seq
// Reset/lock sequencer around the system PLL (24 MHz refclk in, clk0/clk1
// out). Holds the PLL in reset, waits for a stable lock, then releases a
// lock-qualified system reset. Re-resets the PLL when lock does not arrive
// within the timeout window or when lock is lost for LOSS_FILTER cycles in RUN.
//
// Optional feature macro: PLL_RST_SEQ_LOSS_CNT_EN
//   defined   -> adds loss_cnt, a saturating count of RUN->PLL_RST lock losses
//   undefined -> port and counter absent, all else identical
//
// Parameters:
//   PLL_RST_CYCLES : cycles pll_reset is held per attempt (>=1)
//   TIMEOUT_CYCLES : max cycles in WAIT_LOCK before retrying
//   STABLE_CYCLES  : consecutive locked cycles before sys_rst is released
//   LOSS_FILTER    : consecutive unlocked cycles in RUN that count as loss (>=1)
// Ports:
//   refclk    in  1  free-running 24 MHz reference clock
//   reset     in  1  asynchronous reset, active-high
//   extlock   in  1  PLL lock flag, asynchronous to refclk
//   pll_reset out 1  PLL reset, active-high
//   sys_rst   out 1  system reset request, active-high
//   ready     out 1  high only in RUN
//   retry_cnt out 8  lock-timeout retries, saturating
//   loss_cnt  out 8  lock losses in RUN, saturating (macro only)
// ----------------------------------------------------------------------------
module pll_rst_seq
    import pll_rst_seq_pkg::*;
#(
    parameter int PLL_RST_CYCLES = 24,
    parameter int TIMEOUT_CYCLES = 24000,
    parameter int STABLE_CYCLES  = 2400,
    parameter int LOSS_FILTER    = 4
) (
    input  logic             refclk,
    input  logic             reset,
    input  logic             extlock,
    output logic             pll_reset,
    output logic             sys_rst,
    output logic             ready,
    output logic [SAT_W-1:0] retry_cnt
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
    ,
    output logic [SAT_W-1:0] loss_cnt
`endif
);

    localparam int MAX_AB  = (PLL_RST_CYCLES > TIMEOUT_CYCLES) ? PLL_RST_CYCLES : TIMEOUT_CYCLES;
    localparam int MAX_CD  = (STABLE_CYCLES > LOSS_FILTER) ? STABLE_CYCLES : LOSS_FILTER;
    localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOSS_LAST   = CNT_W'(LOSS_FILTER - 1);

    logic             lock_s;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SAT_W-1:0] retry_q, retry_d;
    logic             pll_reset_q;
    logic             sys_rst_q;
    logic             ready_q;
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
    logic [SAT_W-1:0] loss_q, loss_d;
`endif

    sync_2ff u_lock_sync (
        .clk_i (refclk),
        .rst_i (reset),
        .d_i   (extlock),
        .q_o   (lock_s)
    );

    // Next-state logic. The single counter is shared between phases: it
    // times the PLL reset pulse, the lock timeout, the stable window and,
    // in RUN, the run of consecutive unlocked cycles. In RUN the loss is
    // declared on the cycle the count would reach LOSS_FILTER, so the
    // counter never has to hold LOSS_FILTER itself.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
        loss_d  = loss_q;
`endif
        unique case (state_q)
            ST_PLL_RST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = ST_PLL_RST;
                    cnt_d   = '0;
                    retry_d = sat_inc(retry_q);
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_STABLE: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_RUN: begin
                if (lock_s) begin
                    cnt_d = '0;
                end else if (cnt_q == LOSS_LAST) begin
                    state_d = ST_PLL_RST;
                    cnt_d   = '0;
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
                    loss_d  = sat_inc(loss_q);
`endif
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_PLL_RST;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counters and outputs. Outputs are decoded from the next state
    // so they move on the same edge as the state itself, with no extra
    // cycle of lag and no combinational path to the pins.
    always_ff @(posedge refclk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_PLL_RST;
            cnt_q       <= '0;
            retry_q     <= '0;
            pll_reset_q <= 1'b1;
            sys_rst_q   <= 1'b1;
            ready_q     <= 1'b0;
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
            loss_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            pll_reset_q <= (state_d == ST_PLL_RST);
            sys_rst_q   <= (state_d != ST_RUN);
            ready_q     <= (state_d == ST_RUN);
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
            loss_q      <= loss_d;
`endif
        end
    end

    assign pll_reset = pll_reset_q;
    assign sys_rst   = sys_rst_q;
    assign ready     = ready_q;
    assign retry_cnt = retry_q;
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
    assign loss_cnt  = loss_q;
`endif

endmodule

// File: tb/tb_pll_rst_seq.sv
// ----------------------------------------------------------------------------
// tb_pll_rst_seq
// Self-checking bench for pll_rst_seq with PLL_RST_CYCLES=4,
// TIMEOUT_CYCLES=64, STABLE_CYCLES=16, LOSS_FILTER=4. Each test pushes the
// expected per-cycle outputs into a scoreboard queue while it drives extlock
// and reset, and every sampled cycle pops and compares one entry.
// Honours PLL_RST_SEQ_LOSS_CNT_EN to also check loss_cnt.
// ----------------------------------------------------------------------------
module tb_pll_rst_seq;

    typedef struct packed {
        logic       pll;
        logic       sys;
        logic       rdy;
        logic [7:0] retry;
        logic [7:0] loss;
    } exp_t;

    logic       refclk  = 1'b0;
    logic       reset   = 1'b1;
    logic       extlock = 1'b0;
    logic       pll_reset;
    logic       sys_rst;
    logic       ready;
    logic [7:0] retry_cnt;
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
    logic [7:0] loss_cnt;
`endif

    exp_t expQ[$];
    int   nCompared   = 0;
    int   nMismatched = 0;

    pll_rst_seq #(
        .PLL_RST_CYCLES (4),
        .TIMEOUT_CYCLES (64),
        .STABLE_CYCLES  (16),
        .LOSS_FILTER    (4)
    ) dut (
        .refclk    (refclk),
        .reset     (reset),
        .extlock   (extlock),
        .pll_reset (pll_reset),
        .sys_rst   (sys_rst),
        .ready     (ready),
        .retry_cnt (retry_cnt)
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
        ,
        .loss_cnt  (loss_cnt)
`endif
    );

    always #5 refclk = ~refclk;

    // Queue n identical expected cycles.
    task automatic pushExp(input int n, input logic pll, input logic sys,
                           input logic rdy, input int retry, input int loss);
        exp_t e;
        e.pll   = pll;
        e.sys   = sys;
        e.rdy   = rdy;
        e.retry = 8'(retry);
        e.loss  = 8'(loss);
        for (int i = 0; i < n; i++) expQ.push_back(e);
    endtask

    // Pop one expectation and compare it against the outputs right now.
    task automatic checkNow(input string tag);
        exp_t       e;
        logic [10:0] act;
        logic [10:0] req;
        if (expQ.size() == 0) begin
            nCompared++;
            nMismatched++;
            $display("[TB] FAIL %s: scoreboard empty at t=%0t", tag, $time);
        end else begin
            e   = expQ.pop_front();
            act = {pll_reset, sys_rst, ready, retry_cnt};
            req = {e.pll, e.sys, e.rdy, e.retry};
            nCompared++;
            if (act !== req) begin
                nMismatched++;
                $display("[TB] FAIL %s t=%0t: got pll_reset=%b sys_rst=%b ready=%b retry_cnt=%0d, expected %b %b %b %0d",
                         tag, $time, pll_reset, sys_rst, ready, retry_cnt, e.pll, e.sys, e.rdy, e.retry);
            end
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
            nCompared++;
            if (loss_cnt !== e.loss) begin
                nMismatched++;
                $display("[TB] FAIL %s_loss t=%0t: got loss_cnt=%0d, expected %0d",
                         tag, $time, loss_cnt, e.loss);
            end
`endif
        end
    endtask

    // Advance one refclk cycle and sample 1 time unit after the rising edge.
    task automatic step(input string tag);
        @(posedge refclk);
        #1;
        checkNow(tag);
    endtask

    // Hold reset for a few cycles, then release it between edges.
    task automatic test_reset();
        reset   = 1'b1;
        extlock = 1'b0;
        pushExp(3, 1, 1, 0, 0, 0);
        repeat (3) step("reset_hold");
        reset = 1'b0;
    endtask

    // Called right after reset release. PLL_RST ends on edge 4. extlock
    // rises after edge 10: 2 sync edges, 1 WAIT_LOCK sampling edge, then
    // 16 locked STABLE cycles put RUN on edge 29.
    task automatic test_lock_sequence(input string tag);
        pushExp(3, 1, 1, 0, 0, 0);
        pushExp(25, 0, 1, 0, 0, 0);
        pushExp(5, 0, 0, 1, 0, 0);
        repeat (10) step(tag);
        extlock = 1'b1;
        repeat (23) step(tag);
    endtask

    // Three-cycle dropout in RUN stays under the filter.
    task automatic test_short_dropout();
        pushExp(10, 0, 0, 1, 0, 0);
        extlock = 1'b0;
        repeat (3) step("short_dropout");
        extlock = 1'b1;
        repeat (7) step("short_dropout");
    endtask

    // Four-cycle dropout from edge t: lock_s low at edges t+3..t+6, so
    // PLL_RST on t+6 (pll_reset and sys_rst together), WAIT_LOCK on t+10,
    // STABLE on t+11, RUN on t+27.
    task automatic test_lock_loss();
        pushExp(5, 0, 0, 1, 0, 0);
        pushExp(4, 1, 1, 0, 0, 1);
        pushExp(17, 0, 1, 0, 0, 1);
        pushExp(4, 0, 0, 1, 0, 1);
        extlock = 1'b0;
        repeat (4) step("lock_loss");
        extlock = 1'b1;
        repeat (26) step("lock_loss");
    endtask

    // Lose lock, relock after t+10 (STABLE on t+13), then a one-cycle low
    // sampled on t+20 sends it back to WAIT_LOCK; STABLE again on t+21 and
    // RUN only on t+37 rather than t+29.
    task automatic test_stable_glitch();
        pushExp(5, 0, 0, 1, 0, 1);
        pushExp(4, 1, 1, 0, 0, 2);
        pushExp(27, 0, 1, 0, 0, 2);
        pushExp(4, 0, 0, 1, 0, 2);
        extlock = 1'b0;
        repeat (10) step("stable_glitch");
        extlock = 1'b1;
        repeat (7) step("stable_glitch");
        extlock = 1'b0;
        step("stable_glitch");
        extlock = 1'b1;
        repeat (22) step("stable_glitch");
    endtask

    // Lock never returns: WAIT_LOCK from t+10, then a 4-cycle PLL pulse
    // every 68 cycles starting t+74 with retry_cnt stepping 1, 2, 3.
    // Much later retry_cnt must have stuck at 255 after 256 attempts.
    task automatic test_timeout_retry();
        pushExp(5, 0, 0, 1, 0, 2);
        pushExp(4, 1, 1, 0, 0, 3);
        pushExp(64, 0, 1, 0, 0, 3);
        for (int k = 1; k <= 3; k++) begin
            pushExp(4, 1, 1, 0, k, 3);
            if (k < 3) pushExp(64, 0, 1, 0, k, 3);
        end
        pushExp(2, 0, 1, 0, 3, 3);
        extlock = 1'b0;
        repeat (215) step("timeout_retry");
        repeat (17284) @(posedge refclk);
        pushExp(1, 0, 1, 0, 255, 3);
        step("retry_saturate");
    endtask

    // Reach RUN, assert reset mid-cycle and check the outputs without any
    // clock edge, then release and expect the power-up sequence again.
    task automatic test_reset_in_run();
        pushExp(18, 0, 1, 0, 255, 3);
        pushExp(3, 0, 0, 1, 255, 3);
        extlock = 1'b1;
        repeat (21) step("reach_run");
        #3;
        reset   = 1'b1;
        extlock = 1'b0;
        #1;
        pushExp(1, 1, 1, 0, 0, 0);
        checkNow("reset_async");
        pushExp(2, 1, 1, 0, 0, 0);
        repeat (2) step("reset_hold2");
        reset = 1'b0;
        test_lock_sequence("relock");
    endtask

    initial begin
        test_reset();
        test_lock_sequence("lock_seq");
        test_short_dropout();
        test_lock_loss();
        test_stable_glitch();
        test_timeout_retry();
        test_reset_in_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
